// File: rtl/instr_seq_ctrl.sv
// Fetch/load/decode/wait sequencer with PC, IR and HALT handling for the RISC core.
// All outputs come straight from flops; rom_addr is the PC register itself.
module instr_seq_ctrl #(
  parameter int          ADDR_W      = 4,
  parameter int          INSTR_W     = 32,
  parameter int          EXEC_CYCLES = 4,
  parameter logic [4:0]  HALT_OP     = 5'd27
) (
  input  logic               clk,
  input  logic               sys_rst,
  output logic               rom_rd,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_stb,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               resume,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, DECODE, WAIT, HALT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign rom_addr = pc;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      cnt      <= '0;
      rom_rd   <= 1'b0;
      exec_stb <= 1'b0;
      halted   <= 1'b0;
    end else begin
      rom_rd   <= 1'b0;
      exec_stb <= 1'b0;
      case (state)
        IDLE: begin
          state  <= FETCH;
          rom_rd <= 1'b1;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          ir       <= rom_data;
          // strobe is decided one cycle early so it lands registered in DECODE
          exec_stb <= (rom_data[INSTR_W-1 -: 5] != HALT_OP);
          state    <= DECODE;
        end
        DECODE: begin
          if (ir[INSTR_W-1 -: 5] == HALT_OP) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            pc     <= branch_taken ? branch_addr : pc + ADDR_W'(1);
            state  <= FETCH;
            rom_rd <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HALT: begin
          if (resume) begin
            pc     <= pc + ADDR_W'(1);
            halted <= 1'b0;
            state  <= FETCH;
            rom_rd <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
